reg_dump_reader: RTL and testbench

Debug read-out engine for the CPU register file. On a start pulse it walks a contiguous, wrap-around range of register addresses through a spare asynchronous read port. Each captured word is presented as a valid/ready stream beat tagged with its address. It sits beside the register file and feeds the board display/UART path, letting register contents be dumped without halting writeback.

---
 rtl/reg_dump_reader.sv | 121 ++++++++++++
 tb/tb_reg_dump_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: streams a wrap-around range of register-file words as address-tagged valid/ready beats.
// Define REG_DUMP_CHECKSUM_EN to append an XOR checksum beat after the last register beat.
module reg_dump_reader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] SEND  = 3'd2;
   localparam logic [2:0] SUM   = 3'd3;
   localparam logic [2:0] FIN   = 3'd4;
`ifdef REG_DUMP_CHECKSUM_EN
   localparam logic CHK = 1'b1;
   logic [DATA_W-1:0] chk_q, chk_d;
`else
   localparam logic CHK = 1'b0;
`endif
   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d, last_q, last_d, out_addr_q, out_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d, busy_q, busy_d;
   // cur doubles as the read-port address; it only moves on entry to FETCH
   assign rd_addr   = cur_q;
   assign out_valid = (state_q == SEND) || (state_q == SUM);
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = state_q == FIN;
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      last_d     = last_q;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      busy_d     = busy_q;
`ifdef REG_DUMP_CHECKSUM_EN
      chk_d      = chk_q;
`endif
      case (state_q)
         IDLE: if (start) begin
            cur_d   = first_addr;
            last_d  = last_addr;
            busy_d  = 1'b1;
            state_d = FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
            chk_d   = '0;
`endif
         end
         FETCH: begin
            out_data_d = rd_data;
            out_addr_d = cur_q;
            out_last_d = !CHK && (cur_q == last_q);
            state_d    = SEND;
         end
         SEND: if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
            chk_d = chk_q ^ out_data_q;
`endif
            if (cur_q == last_q) begin
               state_d = CHK ? SUM : FIN;
`ifdef REG_DUMP_CHECKSUM_EN
               out_addr_d = '0;
               out_data_d = chk_d;
               out_last_d = 1'b1;
`endif
            end else begin
               cur_d   = cur_q + ADDR_W'(1);
               state_d = FETCH;
            end
         end
         SUM: if (out_ready) state_d = FIN;
         FIN: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cur_q      <= '0;
         last_q     <= '0;
         out_addr_q <= '0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         chk_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cur_q      <= cur_d;
         last_q     <= last_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
         busy_q     <= busy_d;
`ifdef REG_DUMP_CHECKSUM_EN
         chk_q      <= chk_d;
`endif
      end
   end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: scoreboard bench; expected beats come from range arithmetic over a register-file array.
module tb_reg_dump_reader;
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      logic        l;
   } beat_t;
   logic        clk = 0, rst = 1, start = 0, out_ready = 0;
   logic [4:0]  first_addr = 0, last_addr = 0, rd_addr, out_addr;
   logic [31:0] rd_data, out_data;
   logic        out_valid, out_last, busy, done;
   logic [31:0] rf [32];
   beat_t       sbq[$];
   int          n_chk = 0, n_fail = 0, mode = 0;
   logic        done_due = 0, prev_stall = 0, p_last;
   logic [4:0]  p_addr;
   logic [31:0] p_data;
   reg_dump_reader dut (
      .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
      .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
   );
   assign rd_data = rf[rd_addr];
   always #5 clk = ~clk;
   always @(posedge clk) begin
      #1;
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom % 2) : 1'b0;
   end
   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic push_expected(input logic [4:0] f, input logic [4:0] l);
      int n;
      logic [31:0] cs;
      beat_t b;
      n  = ((int'(l) - int'(f) + 32) % 32) + 1;
      cs = 0;
      for (int i = 0; i < n; i++) begin
         b.a = 5'((int'(f) + i) % 32);
         b.d = rf[b.a];
         cs  = cs ^ b.d;
`ifdef REG_DUMP_CHECKSUM_EN
         b.l = 1'b0;
`else
         b.l = (i == n - 1);
`endif
         sbq.push_back(b);
      end
`ifdef REG_DUMP_CHECKSUM_EN
      b.a = 0;
      b.d = cs;
      b.l = 1'b1;
      sbq.push_back(b);
`endif
   endtask
   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         done_due   = 0;
         prev_stall = 0;
      end else begin
         check("done", done, done_due);
         done_due = 0;
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_addr", out_addr, p_addr);
            check("stall_data", out_data, p_data);
            check("stall_last", out_last, p_last);
         end
         prev_stall = out_valid && !out_ready;
         p_addr = out_addr;
         p_data = out_data;
         p_last = out_last;
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) check("unexpected_beat", out_addr, 6'h3f);
            else begin
               e = sbq.pop_front();
               check("beat_addr", out_addr, e.a);
               check("beat_data", out_data, e.d);
               check("beat_last", out_last, e.l);
               done_due = e.l;
            end
         end
      end
   end
   task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
      @(posedge clk);
      #1;
      start = 1;
      first_addr = f;
      last_addr = l;
      push_expected(f, l);
      @(posedge clk);
      #1;
      start = 0;
      @(negedge clk);
      check("fetch_valid", out_valid, 0);
      check("busy_on", busy, 1);
      check("fetch_rd_addr", rd_addr, f);
      @(negedge clk);
      check("first_valid", out_valid, 1);
   endtask
   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (done !== 1'b1 && n < 5000);
      check("done_timeout", n < 5000, 1);
      check("beats_left", sbq.size(), 0);
      check("busy_in_fin", busy, 1);
      @(negedge clk);
      check("busy_off", busy, 0);
      check("idle_valid", out_valid, 0);
   endtask
   initial begin
      for (int i = 0; i < 32; i++) rf[i] = i * 32'h11;
      #23;
      check("rst_rd_addr", rd_addr, 0);
      check("rst_valid", out_valid, 0);
      check("rst_addr", out_addr, 0);
      check("rst_data", out_data, 0);
      check("rst_last", out_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge clk);
      #1 rst = 0;
      mode = 0;
      start_dump(3, 5);
      wait_done();
      start_dump(30, 1);
      wait_done();
      mode = 2;
      start_dump(7, 7);
      repeat (9) begin
         @(negedge clk);
         check("held_valid", out_valid, 1);
      end
      mode = 0;
      wait_done();
      mode = 1;
      start_dump(2, 9);
      repeat (4) @(posedge clk);
      #1;
      start = 1;
      first_addr = 20;
      last_addr = 25;
      @(posedge clk);
      #1;
      start = 0;
      wait_done();
      mode = 2;
      start_dump(0, 31);
      #2 rst = 1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_data", out_data, 0);
      check("arst_rd_addr", rd_addr, 0);
      sbq.delete();
      @(negedge clk);
      #1 rst = 0;
      mode = 0;
      start_dump(4, 4);
      wait_done();
      rf[1] = 32'hA5A5A5A5;
      rf[2] = 32'h0F0F0F0F;
      start_dump(1, 2);
      wait_done();
      mode = 1;
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < 32; i++) rf[i] = $urandom;
         start_dump(5'($urandom), 5'($urandom));
         wait_done();
      end
      start_dump(9, 8);
      wait_done();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
